// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared encodings for the EX-stage ALU controller with its
// iterative multiply/divide unit.
//   - alu_ctrl_e : 4-bit ALU control codes driven to the ALU
//   - ALUOP_*    : main-control op classes
//   - FN_*       : R-type funct field values
//   - md_state_e : multiply/divide sequencer states
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_AND    = 4'b0000,
    ALU_OR     = 4'b0001,
    ALU_ADD    = 4'b0010,
    ALU_MULDIV = 4'b0011,
    ALU_SUB    = 4'b0110,
    ALU_SLT    = 4'b0111,
    ALU_MFHI   = 4'b1000,
    ALU_MFLO   = 4'b1001
  } alu_ctrl_e;

  localparam logic [2:0] ALUOP_R    = 3'b000;
  localparam logic [2:0] ALUOP_ADDI = 3'b001;
  localparam logic [2:0] ALUOP_SLTI = 3'b010;
  localparam logic [2:0] ALUOP_BR   = 3'b011;
  localparam logic [2:0] ALUOP_LD   = 3'b100;
  localparam logic [2:0] ALUOP_ST   = 3'b101;
  localparam logic [2:0] ALUOP_J    = 3'b110;
  localparam logic [2:0] ALUOP_JAL  = 3'b111;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative unsigned multiply / restoring-divide datapath, one
// step per cycle, DATA_W steps per operation. Works on operand magnitudes;
// sign correction is done by the controller.
// Optional feature macro: ALU_CTRL_DIV_EN (builds the divide step and the
// div_op port).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         load operands, clear accumulator and step counter
//   step          perform one iteration
//   div_op        (ALU_CTRL_DIV_EN only) 1 = divide step, 0 = multiply step
//   opa, opb      multiplier/dividend and multiplicand/divisor magnitudes
//   acc_next      accumulator after the current step (HI / remainder)
//   sr_next       shift register after the current step (LO / quotient)
//   last          current step is the final one
module muldiv_iter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
`ifdef ALU_CTRL_DIV_EN
  input  logic              div_op,
`endif
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic [DATA_W-1:0] acc_next,
  output logic [DATA_W-1:0] sr_next,
  output logic              last
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0] sr_reg;
  logic [DATA_W-1:0] opb_reg;
  logic [CNT_W-1:0]  cnt_reg;

  // Shift-add: {acc, sr} holds the partial product; the multiplier is
  // consumed from sr's LSB while product bits shift in from the top.
  logic [DATA_W:0] mul_sum;
  assign mul_sum = {1'b0, acc_reg} + (sr_reg[0] ? {1'b0, opb_reg} : '0);

`ifdef ALU_CTRL_DIV_EN
  // Restoring divide: shift the next dividend bit into the remainder and
  // subtract the divisor if it fits. When it fits the difference is below
  // the divisor, so the low DATA_W bits of the subtraction are exact.
  logic [DATA_W:0]   div_trial;
  logic [DATA_W-1:0] div_diff;
  logic              div_ge;
  assign div_trial = {acc_reg, sr_reg[DATA_W-1]};
  assign div_ge    = (div_trial >= {1'b0, opb_reg});
  assign div_diff  = div_trial[DATA_W-1:0] - opb_reg;
`endif

  always_comb begin
    acc_next = mul_sum[DATA_W:1];
    sr_next  = {mul_sum[0], sr_reg[DATA_W-1:1]};
`ifdef ALU_CTRL_DIV_EN
    if (div_op) begin
      acc_next = div_ge ? div_diff : div_trial[DATA_W-1:0];
      sr_next  = {sr_reg[DATA_W-2:0], div_ge};
    end
`endif
  end

  assign last = (cnt_reg == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
      sr_reg  <= '0;
      opb_reg <= '0;
      cnt_reg <= '0;
    end else if (start) begin
      acc_reg <= '0;
      sr_reg  <= opa;
      opb_reg <= opb;
      cnt_reg <= '0;
    end else if (step) begin
      acc_reg <= acc_next;
      sr_reg  <= sr_next;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// alu_ctrl_muldiv: EX-stage ALU controller. Decodes ALUOp/funct into the
// 4-bit ALU control code and sequences an iterative multiply/divide unit
// that writes the HI/LO registers, stalling the pipeline while it runs.
// Optional feature macro: ALU_CTRL_DIV_EN (div/divu support; without it
// div/divu decode as illegal and no divide hardware is built).
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   valid_i          instruction in EX is valid
//   ALUOp_i          main-control op class
//   funct_i          R-type funct field
//   src1_i, src2_i   rs / rt operands
//   ALUCtrl_o        ALU control code (combinational)
//   stall_o          hold IF/ID/EX this cycle
//   hi_o, lo_o       HI / LO registers
//   illegal_o        valid instruction with undecodable ALUOp/funct
module alu_ctrl_muldiv
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [2:0]        ALUOp_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic [3:0]        ALUCtrl_o,
  output logic              stall_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              illegal_o
);

  md_state_e state_reg, state_next;
  alu_ctrl_e alu_ctrl;
  logic      illegal_fn;
  logic      is_mul;
  logic      is_div;
  logic      is_signed;

  // ---------------- decode ----------------
  always_comb begin
    alu_ctrl   = ALU_AND;
    illegal_fn = 1'b0;
    is_mul     = 1'b0;
    is_div     = 1'b0;
    is_signed  = 1'b0;
    case (ALUOp_i)
      ALUOP_R: begin
        case (funct_i)
          FN_ADD:   alu_ctrl = ALU_ADD;
          FN_SUB:   alu_ctrl = ALU_SUB;
          FN_AND:   alu_ctrl = ALU_AND;
          FN_OR:    alu_ctrl = ALU_OR;
          FN_SLT:   alu_ctrl = ALU_SLT;
          FN_MFHI:  alu_ctrl = ALU_MFHI;
          FN_MFLO:  alu_ctrl = ALU_MFLO;
          FN_MULT:  begin alu_ctrl = ALU_MULDIV; is_mul = 1'b1; is_signed = 1'b1; end
          FN_MULTU: begin alu_ctrl = ALU_MULDIV; is_mul = 1'b1; end
`ifdef ALU_CTRL_DIV_EN
          FN_DIV:   begin alu_ctrl = ALU_MULDIV; is_div = 1'b1; is_signed = 1'b1; end
          FN_DIVU:  begin alu_ctrl = ALU_MULDIV; is_div = 1'b1; end
`endif
          default:  illegal_fn = 1'b1;
        endcase
      end
      ALUOP_ADDI: alu_ctrl = ALU_ADD;
      ALUOP_SLTI: alu_ctrl = ALU_SLT;
      ALUOP_BR:   alu_ctrl = ALU_SUB;
      ALUOP_LD:   alu_ctrl = ALU_ADD;
      ALUOP_ST:   alu_ctrl = ALU_ADD;
      default:    alu_ctrl = ALU_AND;  // jumps: ALU unused
    endcase
  end

  assign ALUCtrl_o = alu_ctrl;
  assign illegal_o = valid_i & illegal_fn;

  // ---------------- operand conditioning ----------------
  logic              start;
  logic              div_zero;
  logic              sign1, sign2;
  logic [DATA_W-1:0] mag1, mag2;

  // A new op is only accepted from IDLE; DONE still holds the finishing op.
  assign start    = valid_i & (is_mul | is_div) & (state_reg == ST_IDLE);
  assign div_zero = is_div & (src2_i == '0);
  assign sign1    = src1_i[DATA_W-1];
  assign sign2    = src2_i[DATA_W-1];
  // The most negative value maps onto itself, which read unsigned is its
  // correct magnitude.
  assign mag1     = (is_signed & sign1) ? -src1_i : src1_i;
  assign mag2     = (is_signed & sign2) ? -src2_i : src2_i;

  logic neg_res_reg;  // product / quotient must be negated
`ifdef ALU_CTRL_DIV_EN
  logic neg_a_reg;    // remainder takes the dividend's sign
  logic op_div_reg;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      neg_res_reg <= 1'b0;
`ifdef ALU_CTRL_DIV_EN
      neg_a_reg   <= 1'b0;
      op_div_reg  <= 1'b0;
`endif
    end else if (start) begin
      neg_res_reg <= is_signed & (sign1 ^ sign2);
`ifdef ALU_CTRL_DIV_EN
      neg_a_reg   <= is_signed & sign1;
      op_div_reg  <= is_div;
`endif
    end
  end

  // ---------------- iterative datapath ----------------
  logic [DATA_W-1:0] acc_next, sr_next;
  logic              iter_last;

  muldiv_iter #(.DATA_W(DATA_W)) u_iter (
    .clk      (clk_i),
    .rst      (rst_i),
    .start    (start),
    .step     (state_reg == ST_BUSY),
`ifdef ALU_CTRL_DIV_EN
    .div_op   (op_div_reg),
`endif
    .opa      (mag1),
    .opb      (mag2),
    .acc_next (acc_next),
    .sr_next  (sr_next),
    .last     (iter_last)
  );

  // The final step's outcome is taken straight from the step logic so the
  // HI/LO write lands on the same edge as the last iteration.
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   res_hi, res_lo;

  assign prod     = {acc_next, sr_next};
  assign prod_fix = neg_res_reg ? -prod : prod;

  always_comb begin
    res_hi = prod_fix[2*DATA_W-1:DATA_W];
    res_lo = prod_fix[DATA_W-1:0];
`ifdef ALU_CTRL_DIV_EN
    if (op_div_reg) begin
      res_hi = neg_a_reg   ? -acc_next : acc_next;
      res_lo = neg_res_reg ? -sr_next  : sr_next;
    end
`endif
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = div_zero ? ST_DONE : ST_BUSY;
      ST_BUSY: if (iter_last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_o = 1'b0;
    case (state_reg)
      ST_IDLE: stall_o = start;
      ST_BUSY: stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
  end

  // ---------------- HI / LO ----------------
  logic [DATA_W-1:0] hi_reg, lo_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (start && div_zero) begin
      hi_reg <= src1_i;
      lo_reg <= '1;
    end else if (state_reg == ST_BUSY && iter_last) begin
      hi_reg <= res_hi;
      lo_reg <= res_lo;
    end
  end

  assign hi_o = hi_reg;
  assign lo_o = lo_reg;

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// tb_alu_ctrl_muldiv: table-driven decode checks plus directed multi-cycle
// multiply/divide, divide-by-zero and reset-abort sequences. Divide cases
// are selected by ALU_CTRL_DIV_EN to match the build of the design.
module tb_alu_ctrl_muldiv;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              valid_i;
  logic [2:0]        ALUOp_i;
  logic [5:0]        funct_i;
  logic [DATA_W-1:0] src1_i, src2_i;
  logic [3:0]        ALUCtrl_o;
  logic              stall_o;
  logic [DATA_W-1:0] hi_o, lo_o;
  logic              illegal_o;

  int checks = 0;
  int errors = 0;

  alu_ctrl_muldiv #(.DATA_W(DATA_W)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ALUOp_i   (ALUOp_i),
    .funct_i   (funct_i),
    .src1_i    (src1_i),
    .src2_i    (src2_i),
    .ALUCtrl_o (ALUCtrl_o),
    .stall_o   (stall_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .illegal_o (illegal_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [2:0] aluop;
    logic [5:0] funct;
    logic       valid;
    logic [3:0] ctrl;
    logic       ill;
  } dec_vec_t;

  dec_vec_t vecs [20];

  // Issue one mul/div instruction in IDLE, hold it while stalled, then
  // retire it in the DONE cycle and compare stall length and HI/LO.
  task automatic run_op(input string name, input logic [5:0] fn,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input int exp_cyc, input logic [DATA_W-1:0] exp_hi,
                        input logic [DATA_W-1:0] exp_lo);
    int cyc;
    @(negedge clk);
    valid_i = 1'b1; ALUOp_i = 3'b000; funct_i = fn; src1_i = a; src2_i = b;
    cyc = 0;
    #1;
    while (stall_o && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    $display("op %s a=%h b=%h stall_cycles=%0d hi=%h lo=%h", name, a, b, cyc, hi_o, lo_o);
    check({name, " stall_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({name, " hi"}, 64'(hi_o), 64'(exp_hi));
    check({name, " lo"}, 64'(lo_o), 64'(exp_lo));
    valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; ALUOp_i = 3'b001; funct_i = 6'd0;
    src1_i = '0; src2_i = '0;

    // Reset state
    #2;
    $display("reset: stall=%b hi=%h lo=%h ctrl=%b", stall_o, hi_o, lo_o, ALUCtrl_o);
    check("reset stall", 64'(stall_o), 64'd0);
    check("reset hi", 64'(hi_o), 64'd0);
    check("reset lo", 64'(lo_o), 64'd0);
    check("reset ctrl follows input", 64'(ALUCtrl_o), 64'b0010);
    @(negedge clk);
    rst_i = 1'b0;

    // Decode table: mul/div entries use valid=0 so the sequencer stays idle
    vecs[0]  = '{3'b000, 6'b100000, 1'b1, 4'b0010, 1'b0};
    vecs[1]  = '{3'b000, 6'b100010, 1'b1, 4'b0110, 1'b0};
    vecs[2]  = '{3'b000, 6'b100100, 1'b1, 4'b0000, 1'b0};
    vecs[3]  = '{3'b000, 6'b100101, 1'b1, 4'b0001, 1'b0};
    vecs[4]  = '{3'b000, 6'b101010, 1'b1, 4'b0111, 1'b0};
    vecs[5]  = '{3'b000, 6'b010000, 1'b1, 4'b1000, 1'b0};
    vecs[6]  = '{3'b000, 6'b010010, 1'b1, 4'b1001, 1'b0};
    vecs[7]  = '{3'b000, 6'b011000, 1'b0, 4'b0011, 1'b0};
    vecs[8]  = '{3'b000, 6'b011001, 1'b0, 4'b0011, 1'b0};
`ifdef ALU_CTRL_DIV_EN
    vecs[9]  = '{3'b000, 6'b011010, 1'b0, 4'b0011, 1'b0};
    vecs[10] = '{3'b000, 6'b011011, 1'b0, 4'b0011, 1'b0};
`else
    vecs[9]  = '{3'b000, 6'b011010, 1'b1, 4'b0000, 1'b1};
    vecs[10] = '{3'b000, 6'b011011, 1'b1, 4'b0000, 1'b1};
`endif
    vecs[11] = '{3'b000, 6'b111111, 1'b1, 4'b0000, 1'b1};
    vecs[12] = '{3'b000, 6'b111111, 1'b0, 4'b0000, 1'b0};
    vecs[13] = '{3'b001, 6'b000000, 1'b1, 4'b0010, 1'b0};
    vecs[14] = '{3'b010, 6'b000000, 1'b1, 4'b0111, 1'b0};
    vecs[15] = '{3'b011, 6'b000000, 1'b1, 4'b0110, 1'b0};
    vecs[16] = '{3'b100, 6'b000000, 1'b1, 4'b0010, 1'b0};
    vecs[17] = '{3'b101, 6'b000000, 1'b1, 4'b0010, 1'b0};
    vecs[18] = '{3'b110, 6'b100000, 1'b1, 4'b0000, 1'b0};
    vecs[19] = '{3'b111, 6'b100010, 1'b1, 4'b0000, 1'b0};

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      valid_i = vecs[i].valid; ALUOp_i = vecs[i].aluop; funct_i = vecs[i].funct;
      src1_i = 32'h0000000A; src2_i = '0;
      #1;
      $display("vec %0d aluop=%b funct=%b valid=%b ctrl=%b illegal=%b stall=%b",
               i, vecs[i].aluop, vecs[i].funct, vecs[i].valid, ALUCtrl_o, illegal_o, stall_o);
      check($sformatf("vec%0d ctrl", i), 64'(ALUCtrl_o), 64'(vecs[i].ctrl));
      check($sformatf("vec%0d illegal", i), 64'(illegal_o), 64'(vecs[i].ill));
      check($sformatf("vec%0d stall", i), 64'(stall_o), 64'd0);
    end
    @(negedge clk);
    valid_i = 1'b0;

    // Multiply sequences: start cycle + 32 busy cycles stalled
    run_op("mult -3*5",   6'b011000, 32'hFFFFFFFD, 32'h00000005, 33, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu ffffffff*2", 6'b011001, 32'hFFFFFFFF, 32'h00000002, 33, 32'h00000001, 32'hFFFFFFFE);
    run_op("mult 7*-8",   6'b011000, 32'h00000007, 32'hFFFFFFF8, 33, 32'hFFFFFFFF, 32'hFFFFFFC8);
    run_op("multu 2^31*2^31", 6'b011001, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h00000000);

`ifdef ALU_CTRL_DIV_EN
    run_op("div -7/2",    6'b011010, 32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu 10/0",   6'b011011, 32'h0000000A, 32'h00000000, 1,  32'h0000000A, 32'hFFFFFFFF);
    run_op("div min/-1",  6'b011010, 32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000);
    run_op("divu 100/7",  6'b011011, 32'h00000064, 32'h00000007, 33, 32'h00000002, 32'h0000000E);
    run_op("div 7/-2",    6'b011010, 32'h00000007, 32'hFFFFFFFE, 33, 32'h00000001, 32'hFFFFFFFD);
`else
    // div not built: illegal, no stall, HI/LO keep the last multiply result
    @(negedge clk);
    valid_i = 1'b1; ALUOp_i = 3'b000; funct_i = 6'b011010;
    src1_i = 32'h00000007; src2_i = 32'h00000000;
    #1;
    $display("op div-disabled illegal=%b stall=%b ctrl=%b", illegal_o, stall_o, ALUCtrl_o);
    check("div-off illegal", 64'(illegal_o), 64'd1);
    check("div-off stall", 64'(stall_o), 64'd0);
    check("div-off ctrl", 64'(ALUCtrl_o), 64'd0);
    @(negedge clk);
    #1;
    check("div-off stall next", 64'(stall_o), 64'd0);
    check("div-off hi kept", 64'(hi_o), 64'h40000000);
    check("div-off lo kept", 64'(lo_o), 64'h00000000);
    valid_i = 1'b0;
`endif

    // Load known nonzero HI/LO, then abort a later mult with reset
    run_op("multu ffffffff*2 pre-reset", 6'b011001, 32'hFFFFFFFF, 32'h00000002, 33,
           32'h00000001, 32'hFFFFFFFE);
    @(negedge clk);
    valid_i = 1'b1; ALUOp_i = 3'b000; funct_i = 6'b011000;
    src1_i = 32'h00000003; src2_i = 32'h00000005;
    repeat (11) @(negedge clk);
    #1;
    check("busy10 stall", 64'(stall_o), 64'd1);
    rst_i = 1'b1; valid_i = 1'b0;
    #1;
    $display("reset mid-op: stall=%b hi=%h lo=%h", stall_o, hi_o, lo_o);
    check("abort stall", 64'(stall_o), 64'd0);
    check("abort hi", 64'(hi_o), 64'd0);
    check("abort lo", 64'(lo_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk);
    #1;
    check("after abort stall", 64'(stall_o), 64'd0);
    check("after abort hi", 64'(hi_o), 64'd0);
    check("after abort lo", 64'(lo_o), 64'd0);

    // Sequencer is usable again after the abort
    run_op("mult -3*5 after reset", 6'b011000, 32'hFFFFFFFD, 32'h00000005, 33,
           32'hFFFFFFFF, 32'hFFFFFFF1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_muldiv.md
# alu_ctrl_muldiv

Parametrised successor to the single-cycle ALU controller: decodes ALUOp/funct into the 4-bit ALU control code and additionally sequences an iterative multiply/divide unit with HI/LO registers. Sits in the EX stage of the MIPS pipeline. Drives a stall to hazard logic while a multi-cycle operation is in flight.

## Interface
- DATA_W, 32: operand and HI/LO width (≥ 4, even).
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  instruction in EX is valid.
- ALUOp_i  in  3  main-control op class.
- funct_i  in  6  R-type funct field.
- src1_i  in  DATA_W  rs operand.
- src2_i  in  DATA_W  rt operand.
- ALUCtrl_o  out  4  ALU control code (combinational).
- stall_o  out  1  hold IF/ID/EX this cycle.
- hi_o  out  DATA_W  HI register.
- lo_o  out  DATA_W  LO register.
- illegal_o  out  1  valid_i with undecodable ALUOp/funct (combinational).

## Operation
- ALUOp 000 (R): funct 100000→0010 add, 100010→0110 sub, 100100→0000 and, 100101→0001 or, 101010→0111 slt, 010000→1000 mfhi, 010010→1001 mflo, 011000/011001/011010/011011 (mult/multu/div/divu)→0011.
- ALUOp 001→0010, 010→0111, 011→0110, 100→0010, 101→0010; 110/111→0000 (jump, no ALU use).
- Unlisted funct under ALUOp 000: ALUCtrl_o=0000, illegal_o=valid_i; no state change.
- FSM IDLE/BUSY/DONE.
  - IDLE: valid_i & mul/div → latch |operands| and sign flags, counter=0, go BUSY; stall_o=1 this cycle.
  - BUSY: one shift-add (mult) or restoring-subtract (div) step per cycle; stall_o=1; inputs ignored. At counter=DATA_W−1, edge writes sign-corrected result to HI/LO, go DONE.
  - DONE: stall_o=0 (the op leaves EX at this edge); no new start accepted; always → IDLE.
- mult/multu: {HI,LO}=src1×src2, 2·DATA_W bits, signed or unsigned.
- div/divu: LO=quotient, HI=remainder; signed truncates toward zero, remainder takes dividend sign.
- Divide by zero: no iteration; IDLE→DONE directly, LO=all ones, HI=src1.
- Signed min/−1: LO=min value (wraps), HI=0.
- mfhi/mflo with valid_i while BUSY: impossible (pipeline held); in IDLE/DONE hi_o/lo_o are current.

## Timing
- Reset: state IDLE, counter 0, HI=LO=0, stall_o=0; ALUCtrl_o/illegal_o follow inputs.
- Reset mid-operation: abort immediately, HI/LO=0, no partial write.
- mul/div latency: start cycle + DATA_W BUSY cycles stalled; result visible in DONE cycle (DATA_W+1 edges after start). Div-by-zero: 1 stall cycle, result in next cycle.
- stall_o is combinational from valid_i/ALUOp_i/funct_i in IDLE, registered-state-derived otherwise.

## Configuration
- ALU_CTRL_DIV_EN defined: div/divu supported as above.
- Undefined: div/divu decode as illegal (ALUCtrl_o=0000, illegal_o=1), no stall, HI/LO unchanged; divide datapath not built.

## Structure
- Package alu_ctrl_pkg: ALUCtrl codes, ALUOp codes, funct codes, FSM state encoding.
- Sub-module muldiv_iter: iterative DATA_W-step datapath (accumulator, shift register, counter); controller owns decode, FSM, sign handling, HI/LO.

## Test plan
- Decode sweep: each ALUOp 001–111 and each listed funct → listed ALUCtrl_o; funct 111111 with valid_i=1 → ALUCtrl_o=0000, illegal_o=1, stall_o=0.
- mult src1=FFFFFFFD (−3), src2=5 → stall_o high 33 cycles, then HI=FFFFFFFF, LO=FFFFFFF1, stall_o=0 in DONE.
- multu FFFFFFFF×00000002 → HI=00000001, LO=FFFFFFFE.
- div FFFFFFF9 (−7) / 2 → LO=FFFFFFFD, HI=FFFFFFFF; divu 0000000A/0 → 1 stall cycle, LO=FFFFFFFF, HI=0000000A.
- rst_i pulsed at BUSY cycle 10 of a mult → next cycle IDLE, stall_o=0, HI=LO=0.
- Build without ALU_CTRL_DIV_EN: div with valid_i → illegal_o=1, no stall, HI/LO keep prior mult values.
